// File: rtl/load_store_unit_if.sv
// Purpose : request/response and data-memory port bundle for the load/store unit.
// Latency : none (wires only).
// Backpressure: req_valid/req_ready handshake; the memory side has none.
// master = the LSU itself, slave = core + data memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// Purpose : single-outstanding load/store master for a word-only data memory (RMW for SB/SH).
// Latency : response in cycle 1 (error), 2 (SW), 3 (loads), 4 (SB/SH) after the accept edge.
// Backpressure: req_ready only in IDLE; requests presented while busy are ignored.
// Ports: clk, rst (async active-high), bus (load_store_unit_if.master): req_* from the core,
// resp_* pulse back to the core, mem_* word-addressed read/write port to the data memory.
module load_store_unit (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.master  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] merged_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_err;
    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Decode the incoming request: illegal width codes, misalignment, unsigned stores.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = bus.req_addr[0];
            3'b010:  req_err = (bus.req_addr[1:0] != 2'b00);
            3'b100:  req_err = bus.req_we;
            3'b101:  req_err = bus.req_we | bus.req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // Lane selection from the returned word, shared by load extract and store merge.
    always_comb begin
        shifted  = bus.mem_read_data >> {addr_q[1:0], 3'b000};
        sel_byte = shifted[7:0];
        sel_half = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

        load_val = bus.mem_read_data;
        case (f3_q[1:0])
            2'b00:   load_val = f3_q[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            2'b01:   load_val = f3_q[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: load_val = bus.mem_read_data;
        endcase

        merged = bus.mem_read_data;
        if (f3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merged[31:16] = wdata_q[15:0];
        else
            merged[15:0] = wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            f3_q     <= 3'd0;
            merged_q <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        if (req_err) begin
                            rdata_q <= 32'd0;
                            err_q   <= 1'b1;
                            state   <= S_RESP;
                        end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
                            state   <= S_WRITE;
                        end else begin
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (we_q) begin
                        merged_q <= merged;
                        state    <= S_WRITE;
                    end else begin
                        // Response registers are only touched on the edge into RESP,
                        // so the previous response stays visible until then.
                        rdata_q <= load_val;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end
                end
                S_WRITE: begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                    state   <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready        = (state == S_IDLE);
    assign bus.resp_valid       = (state == S_RESP);
    assign bus.resp_rdata       = rdata_q;
    assign bus.resp_err         = err_q;
    assign bus.mem_read_addr    = {addr_q[31:2], 2'b00};
    assign bus.mem_write_addr   = {addr_q[31:2], 2'b00};
    // Strobe is decoded from state so an async reset kills an in-progress write at once.
    assign bus.mem_write_enable = (state == S_WRITE);
    assign bus.mem_write_data   = (f3_q == 3'b010) ? wdata_q : merged_q;

endmodule
